// File: rtl/mux2a1_cond_l2_if.sv
// Bus interface for the L2 2-to-1 combining mux.
// Handshake: an input word on lane N is taken at a rising clk_2f edge
// exactly when validN and readyN are both high; validN high while readyN
// is low at an edge (outside reset) drops the word and sets overflowN.
// validout is a one-cycle strobe: high for exactly the cycle after the edge
// that loaded a new word into data_out_muxL2. There is no back-pressure on
// the output side.
// dbg_count0/dbg_count1 expose the FIFO occupancies for observation.
interface mux2a1_cond_l2_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              valid0;
    logic [DATA_W-1:0] data_in0;
    logic              valid1;
    logic [DATA_W-1:0] data_in1;
    logic              ready0;
    logic              ready1;
    logic              validout;
    logic [DATA_W-1:0] data_out_muxL2;
    logic              lane_id;
    logic              selectorL2;
    logic              overflow0;
    logic              overflow1;
    logic [CW-1:0]     dbg_count0;
    logic [CW-1:0]     dbg_count1;

    // Source side: drives the two input lanes, observes everything else.
    modport master (
        output valid0, data_in0, valid1, data_in1,
        input  ready0, ready1, validout, data_out_muxL2, lane_id,
        input  selectorL2, overflow0, overflow1, dbg_count0, dbg_count1
    );

    // Mux side.
    modport slave (
        input  valid0, data_in0, valid1, data_in1,
        output ready0, ready1, validout, data_out_muxL2, lane_id,
        output selectorL2, overflow0, overflow1, dbg_count0, dbg_count1
    );
endinterface

// File: rtl/mux2a1_cond_l2.sv
// mux2a1_cond_l2: layer-2 combining mux. Two byte lanes are each buffered
// in a FIFO_DEPTH-word FIFO; a selector alternates between lanes every
// clk_2f cycle and the served word is registered onto data_out_muxL2 with
// its source lane in lane_id.
// Optional feature: define SKIP_EMPTY_EN for work-conserving scheduling
// (an empty selected lane yields its slot to the other lane). Without it,
// the selector alternates strictly and empty slots give validout = 0.
module mux2a1_cond_l2 #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk_2f,
    input logic             reset,
    mux2a1_cond_l2_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // FIFO storage and bookkeeping, one set per lane
    logic [DATA_W-1:0] mem0_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem1_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr0_q, wptr0_d, rptr0_q, rptr0_d;
    logic [AW-1:0]     wptr1_q, wptr1_d, rptr1_q, rptr1_d;
    logic [CW-1:0]     cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Output and scheduler registers
    logic              validout_q, validout_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              lane_q, lane_d;
    logic              sel_q, sel_d;
    logic              ovf0_q, ovf0_d, ovf1_q, ovf1_d;

    // Handshake and scheduling decisions
    logic              ready0, ready1;
    logic              push0, push1;
    logic              drop0, drop1;
    logic              empty0, empty1;
    logic              pop0, pop1;
    logic              serve_any;
    logic              serve_lane;
    logic [DATA_W-1:0] head;

    // Input-side acceptance: ready is forced low during reset so nothing
    // is taken while the FIFOs are being flushed.
    always_comb begin
        ready0 = !reset && (cnt0_q != FULL_CNT);
        ready1 = !reset && (cnt1_q != FULL_CNT);
        push0  = bus.valid0 && ready0;
        push1  = bus.valid1 && ready1;
        drop0  = bus.valid0 && !ready0 && !reset;
        drop1  = bus.valid1 && !ready1 && !reset;
        empty0 = (cnt0_q == '0);
        empty1 = (cnt1_q == '0);
    end

    // Scheduler: decide which FIFO (if any) is popped at this edge and what
    // the selector becomes. Emptiness is judged on pre-edge counts, so a
    // word pushed at this same edge is never popped by it.
    always_comb begin
        pop0       = 1'b0;
        pop1       = 1'b0;
        serve_lane = sel_q;
`ifdef SKIP_EMPTY_EN
        if (!sel_q) begin
            if (!empty0) begin
                pop0       = 1'b1;
                serve_lane = 1'b0;
            end else if (!empty1) begin
                pop1       = 1'b1;
                serve_lane = 1'b1;
            end
        end else begin
            if (!empty1) begin
                pop1       = 1'b1;
                serve_lane = 1'b1;
            end else if (!empty0) begin
                pop0       = 1'b1;
                serve_lane = 1'b0;
            end
        end
`else
        if (!sel_q) begin
            pop0 = !empty0;
        end else begin
            pop1 = !empty1;
        end
`endif
        serve_any = pop0 || pop1;
        // With no pop, serve_lane equals sel_q, so this also covers the
        // plain alternation case.
        sel_d     = ~serve_lane;
    end

    // Head word of the lane being served
    always_comb begin
        head = serve_lane ? mem1_q[rptr1_q] : mem0_q[rptr0_q];
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wptr0_d = wptr0_q;
        rptr0_d = rptr0_q;
        wptr1_d = wptr1_q;
        rptr1_d = rptr1_q;
        if (push0) wptr0_d = wptr0_q + AW'(1);
        if (pop0)  rptr0_d = rptr0_q + AW'(1);
        if (push1) wptr1_d = wptr1_q + AW'(1);
        if (pop1)  rptr1_d = rptr1_q + AW'(1);
        cnt0_d = cnt0_q + CW'(push0) - CW'(pop0);
        cnt1_d = cnt1_q + CW'(push1) - CW'(pop1);
    end

    // Output register next-state: data and lane hold when nothing is served
    always_comb begin
        validout_d = serve_any;
        data_d     = serve_any ? head : data_q;
        lane_d     = serve_any ? serve_lane : lane_q;
        ovf0_d     = ovf0_q || drop0;
        ovf1_d     = ovf1_q || drop1;
    end

    // FIFO data storage; contents need no reset because pointers gate reads
    always_ff @(posedge clk_2f) begin
        if (push0) mem0_q[wptr0_q] <= bus.data_in0;
        if (push1) mem1_q[wptr1_q] <= bus.data_in1;
    end

    // Control state with synchronous flush
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            wptr0_q    <= '0;
            rptr0_q    <= '0;
            cnt0_q     <= '0;
            wptr1_q    <= '0;
            rptr1_q    <= '0;
            cnt1_q     <= '0;
            validout_q <= 1'b0;
            data_q     <= '0;
            lane_q     <= 1'b0;
            sel_q      <= 1'b0;
            ovf0_q     <= 1'b0;
            ovf1_q     <= 1'b0;
        end else begin
            wptr0_q    <= wptr0_d;
            rptr0_q    <= rptr0_d;
            cnt0_q     <= cnt0_d;
            wptr1_q    <= wptr1_d;
            rptr1_q    <= rptr1_d;
            cnt1_q     <= cnt1_d;
            validout_q <= validout_d;
            data_q     <= data_d;
            lane_q     <= lane_d;
            sel_q      <= sel_d;
            ovf0_q     <= ovf0_d;
            ovf1_q     <= ovf1_d;
        end
    end

    // Drive the interface outputs
    assign bus.ready0         = ready0;
    assign bus.ready1         = ready1;
    assign bus.validout       = validout_q;
    assign bus.data_out_muxL2 = data_q;
    assign bus.lane_id        = lane_q;
    assign bus.selectorL2     = sel_q;
    assign bus.overflow0      = ovf0_q;
    assign bus.overflow1      = ovf1_q;
    assign bus.dbg_count0     = cnt0_q;
    assign bus.dbg_count1     = cnt1_q;
endmodule

// File: tb/tb_mux2a1_cond_l2.sv
// Testbench for mux2a1_cond_l2. A queue-based reference model (one queue
// per lane plus the scheduler rule) predicts every output after each edge.
// Build with or without +define+SKIP_EMPTY_EN; expectations follow the macro.
module tb_mux2a1_cond_l2;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    // Clock / reset
    logic clk_2f = 1'b0;
    logic reset;
    always #5 clk_2f = ~clk_2f;

    mux2a1_cond_l2_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    mux2a1_cond_l2 #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] mq0[$];
    logic [DATA_W-1:0] mq1[$];
    logic [DATA_W-1:0] acc0_log[$];
    logic              m_valid, m_lane, m_sel, m_ovf0, m_ovf1;
    logic [DATA_W-1:0] m_data;

    // Advance the model by one edge using the inputs applied before it
    task automatic model_edge();
        bit acc0, acc1, take0, take1;
        if (reset) begin
            mq0.delete();
            mq1.delete();
            m_valid = 1'b0; m_data = '0; m_lane = 1'b0;
            m_sel = 1'b0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
        end else begin
            acc0 = bus.valid0 && (mq0.size() < FIFO_DEPTH);
            acc1 = bus.valid1 && (mq1.size() < FIFO_DEPTH);
            if (bus.valid0 && !acc0) m_ovf0 = 1'b1;
            if (bus.valid1 && !acc1) m_ovf1 = 1'b1;
            take0 = 1'b0;
            take1 = 1'b0;
            if (m_sel == 1'b0 && mq0.size() > 0) take0 = 1'b1;
            else if (m_sel == 1'b1 && mq1.size() > 0) take1 = 1'b1;
`ifdef SKIP_EMPTY_EN
            else if (mq0.size() > 0) take0 = 1'b1;
            else if (mq1.size() > 0) take1 = 1'b1;
`endif
            if (take0) begin
                m_data = mq0.pop_front(); m_lane = 1'b0; m_valid = 1'b1; m_sel = 1'b1;
            end else if (take1) begin
                m_data = mq1.pop_front(); m_lane = 1'b1; m_valid = 1'b1; m_sel = 1'b0;
            end else begin
                m_valid = 1'b0; m_sel = ~m_sel;
            end
            if (acc0) begin
                mq0.push_back(bus.data_in0);
                acc0_log.push_back(bus.data_in0);
            end
            if (acc1) mq1.push_back(bus.data_in1);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk_2f);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [DATA_W-1:0] d1);
        bus.valid0 = v0; bus.data_in0 = d0;
        bus.valid1 = v1; bus.data_in1 = d1;
    endtask

    task automatic do_reset(input int n);
        drive(1'b0, '0, 1'b0, '0);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bit found;
        reset = 1'b1;
        drive(1'b1, 8'hFF, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.ready0 !== 1'b0) begin
                failures++; $display("FAIL reset_ready0: got %b expected 0", bus.ready0);
            end
            tick();
            checks++;
            if (bus.validout !== 1'b0) begin
                failures++; $display("FAIL reset_validout: got %b expected 0", bus.validout);
            end
            checks++;
            if (bus.data_out_muxL2 !== 8'h00) begin
                failures++; $display("FAIL reset_data: got %h expected 00", bus.data_out_muxL2);
            end
            checks++;
            if (bus.overflow0 !== 1'b0) begin
                failures++; $display("FAIL reset_overflow0: got %b expected 0", bus.overflow0);
            end
        end
        reset = 1'b0;
        drive(1'b1, 8'h3C, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick();
            if (bus.validout === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL reset_first_word: got none expected 3c within 6 cycles");
        end else if (bus.data_out_muxL2 !== 8'h3C || bus.lane_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_word: got %h lane %b expected 3c lane 0",
                     bus.data_out_muxL2, bus.lane_id);
        end
    endtask

    task automatic test_interleave();
        logic [DATA_W-1:0] exp_d[4];
        logic              exp_l[4];
        exp_d[0] = 8'hA0; exp_d[1] = 8'hB0; exp_d[2] = 8'hA1; exp_d[3] = 8'hB1;
        exp_l[0] = 1'b0;  exp_l[1] = 1'b1;  exp_l[2] = 1'b0;  exp_l[3] = 1'b1;
        do_reset(1);
        for (int i = 0; i < 3 && m_sel !== 1'b1; i++) tick();
        drive(1'b1, 8'hA0, 1'b1, 8'hB0);
        tick();
        drive(1'b1, 8'hA1, 1'b1, 8'hB1);
        for (int k = 0; k < 5; k++) begin
            tick();
            drive(1'b0, '0, 1'b0, '0);
            checks++;
            if (k < 4) begin
                if (bus.validout !== 1'b1 || bus.data_out_muxL2 !== exp_d[k] ||
                    bus.lane_id !== exp_l[k]) begin
                    failures++;
                    $display("FAIL interleave_%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             k, bus.validout, bus.data_out_muxL2, bus.lane_id, exp_d[k], exp_l[k]);
                end
            end else if (bus.validout !== 1'b0) begin
                failures++; $display("FAIL interleave_tail: got v=%b expected 0", bus.validout);
            end
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] got[$];
        bit saw_low;
        do_reset(1);
        acc0_log.delete();
        saw_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0, '0);
            #1;
            checks++;
            if (bus.ready0 !== (mq0.size() < FIFO_DEPTH)) begin
                failures++;
                $display("FAIL overflow_ready0_%0d: got %b expected %b", i, bus.ready0,
                         mq0.size() < FIFO_DEPTH);
            end
            if (bus.ready0 === 1'b0) saw_low = 1'b1;
            tick();
            if (bus.validout === 1'b1) got.push_back(bus.data_out_muxL2);
        end
        drive(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.validout === 1'b1) got.push_back(bus.data_out_muxL2);
        end
`ifndef SKIP_EMPTY_EN
        checks++;
        if (!saw_low) begin
            failures++; $display("FAIL overflow_ready_fell: got ready0 always 1 expected a 0");
        end
        checks++;
        if (bus.overflow0 !== 1'b1) begin
            failures++; $display("FAIL overflow_flag0: got %b expected 1", bus.overflow0);
        end
`endif
        checks++;
        if (bus.overflow1 !== 1'b0) begin
            failures++; $display("FAIL overflow_flag1: got %b expected 0", bus.overflow1);
        end
        checks++;
        if (got.size() != acc0_log.size()) begin
            failures++;
            $display("FAIL overflow_count: got %0d words expected %0d", got.size(), acc0_log.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                checks++;
                if (got[i] !== acc0_log[i] || (i > 0 && got[i] <= got[i-1])) begin
                    failures++;
                    $display("FAIL overflow_word_%0d: got %h expected %h ascending", i, got[i], acc0_log[i]);
                end
            end
        end
    endtask

    task automatic test_sparse();
        int   nvalid;
        logic prev_sel;
        do_reset(1);
        nvalid = 0;
        drive(1'b0, '0, 1'b1, 8'h55);
        for (int i = 0; i < 7; i++) begin
            prev_sel = bus.selectorL2;
            tick();
            drive(1'b0, '0, 1'b0, '0);
            if (bus.validout === 1'b1) begin
                nvalid++;
                checks++;
                if (bus.lane_id !== 1'b1 || prev_sel !== 1'b1 || bus.data_out_muxL2 !== 8'h55) begin
                    failures++;
                    $display("FAIL sparse_word: got l=%b prev_sel=%b d=%h expected l=1 prev_sel=1 d=55",
                             bus.lane_id, prev_sel, bus.data_out_muxL2);
                end
            end
        end
        checks++;
        if (nvalid != 1) begin
            failures++; $display("FAIL sparse_valid_cycles: got %0d expected 1", nvalid);
        end
        checks++;
        if (bus.data_out_muxL2 !== 8'h55 || bus.validout !== 1'b0) begin
            failures++;
            $display("FAIL sparse_hold: got d=%h v=%b expected d=55 v=0", bus.data_out_muxL2, bus.validout);
        end
    endtask

    task automatic test_skip_empty();
        int                idx[$];
        logic [DATA_W-1:0] dat[$];
        int                gap;
`ifdef SKIP_EMPTY_EN
        gap = 1;
`else
        gap = 2;
`endif
        do_reset(1);
        for (int i = 0; i < 14; i++) begin
            if (i < 4) drive(1'b1, 8'(i + 1), 1'b0, '0);
            else       drive(1'b0, '0, 1'b0, '0);
            tick();
            if (bus.validout === 1'b1) begin
                idx.push_back(i);
                dat.push_back(bus.data_out_muxL2);
            end
        end
        checks++;
        if (idx.size() != 4) begin
            failures++; $display("FAIL skip_count: got %0d expected 4", idx.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dat[k] !== 8'(k + 1) || (k > 0 && idx[k] - idx[k-1] != gap)) begin
                    failures++;
                    $display("FAIL skip_word_%0d: got d=%h gap=%0d expected d=%h gap=%0d", k, dat[k],
                             (k > 0) ? idx[k] - idx[k-1] : gap, 8'(k + 1), gap);
                end
            end
        end
    endtask

    task automatic test_midop_reset();
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 8'(8'hC1 + i));
            tick();
        end
        drive(1'b0, '0, 1'b0, '0);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.ready1 !== 1'b0) begin
            failures++; $display("FAIL midreset_ready1: got %b expected 0", bus.ready1);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (bus.dbg_count0 !== '0 || bus.dbg_count1 !== '0 || bus.validout !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: got c0=%0d c1=%0d v=%b expected 0 0 0",
                     bus.dbg_count0, bus.dbg_count1, bus.validout);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.validout !== 1'b0) begin
                failures++;
                $display("FAIL midreset_emit_%0d: got v=1 d=%h expected v=0", i, bus.data_out_muxL2);
            end
        end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45, 8'($urandom));
            #1;
            checks++;
            if (bus.ready0 !== (!reset && mq0.size() < FIFO_DEPTH) ||
                bus.ready1 !== (!reset && mq1.size() < FIFO_DEPTH)) begin
                failures++;
                $display("FAIL rand_ready_%0d: got %b%b expected %b%b", i, bus.ready0, bus.ready1,
                         !reset && mq0.size() < FIFO_DEPTH, !reset && mq1.size() < FIFO_DEPTH);
            end
            tick();
            checks++;
            if (bus.validout !== m_valid || bus.data_out_muxL2 !== m_data || bus.lane_id !== m_lane ||
                bus.selectorL2 !== m_sel || bus.overflow0 !== m_ovf0 || bus.overflow1 !== m_ovf1 ||
                bus.dbg_count0 !== CW'(mq0.size()) || bus.dbg_count1 !== CW'(mq1.size())) begin
                failures++;
                $display("FAIL rand_out_%0d: got v=%b d=%h l=%b s=%b o=%b%b c=%0d/%0d expected v=%b d=%h l=%b s=%b o=%b%b c=%0d/%0d",
                         i, bus.validout, bus.data_out_muxL2, bus.lane_id, bus.selectorL2,
                         bus.overflow0, bus.overflow1, bus.dbg_count0, bus.dbg_count1,
                         m_valid, m_data, m_lane, m_sel, m_ovf0, m_ovf1, mq0.size(), mq1.size());
            end
        end
        reset = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0);
        test_reset();
        test_interleave();
        test_overflow();
`ifndef SKIP_EMPTY_EN
        test_sparse();
`endif
        test_skip_empty();
        test_midop_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
